// File: rtl/fpmult.sv
// fpmult: multi-cycle IEEE-754 binary32 multiplier.
// One product per reset release: the operands are captured on the first edge
// with reset high, and the product appears four stages later with done held
// high until the next reset.
// Denormal inputs are flushed to zero, and tiny results flush to signed zero.
//
// Ports:
//   clk    - system clock, rising edge
//   reset  - synchronous, active-low; low clears the unit and re-arms LOAD
//   dataa  - operand A (binary32), sampled in LOAD only
//   datab  - operand B (binary32), sampled in LOAD only
//   result - registered product (binary32)
//   done   - high once result is valid, held until the next reset
module fpmult (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] dataa,
  input  logic [31:0] datab,
  output logic [31:0] result,
  output logic        done
);

  typedef enum logic [2:0] {LOAD, MULT, NORM, ROUND, DONE} state_t;

  localparam logic [31:0] QNAN = 32'h7FC00000;

  state_t      state_q, state_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic        sign_q, sign_d;
  logic        special_q, special_d;
  logic [31:0] special_val_q, special_val_d;
  logic [9:0]  exp_q, exp_d;
  logic [47:0] prod_q, prod_d;
  logic [23:0] mant_q, mant_d;
  logic        guard_q, guard_d;
  logic        sticky_q, sticky_d;
  logic [31:0] pack_q, pack_d;
  logic [31:0] result_q, result_d;
  logic        done_q, done_d;

  // Operand classification on the captured operands. An exponent of zero
  // covers both true zero and denormals, which are treated as zero.
  logic        zero_a, zero_b, inf_a, inf_b, nan_a, nan_b;
  logic [47:0] sig_a, sig_b;
  logic        prod_sign;
  logic        round_up;
  logic [24:0] mant_rnd;
  logic [9:0]  exp_rnd;

  assign zero_a = (a_q[30:23] == 8'h00);
  assign zero_b = (b_q[30:23] == 8'h00);
  assign inf_a  = (a_q[30:23] == 8'hFF) && (a_q[22:0] == 23'd0);
  assign inf_b  = (b_q[30:23] == 8'hFF) && (b_q[22:0] == 23'd0);
  assign nan_a  = (a_q[30:23] == 8'hFF) && (a_q[22:0] != 23'd0);
  assign nan_b  = (b_q[30:23] == 8'hFF) && (b_q[22:0] != 23'd0);
  assign sig_a  = {24'd0, 1'b1, a_q[22:0]};
  assign sig_b  = {24'd0, 1'b1, b_q[22:0]};
  assign prod_sign = a_q[31] ^ b_q[31];

  // Next-state and datapath logic. Each state does one pipeline step and
  // hands off to the next; DONE latches the packed result exactly once.
  always_comb begin
    state_d       = state_q;
    a_d           = a_q;
    b_d           = b_q;
    sign_d        = sign_q;
    special_d     = special_q;
    special_val_d = special_val_q;
    exp_d         = exp_q;
    prod_d        = prod_q;
    mant_d        = mant_q;
    guard_d       = guard_q;
    sticky_d      = sticky_q;
    pack_d        = pack_q;
    result_d      = result_q;
    done_d        = done_q;
    round_up      = 1'b0;
    mant_rnd      = 25'd0;
    exp_rnd       = 10'd0;

    case (state_q)
      LOAD: begin
        a_d     = dataa;
        b_d     = datab;
        state_d = MULT;
      end

      MULT: begin
        sign_d = prod_sign;
        prod_d = sig_a * sig_b;
        // 10-bit wrap arithmetic gives the two's-complement biased sum.
        exp_d  = {2'b00, a_q[30:23]} + {2'b00, b_q[30:23]} - 10'd127;
        // Special operands are resolved here; the normal path still runs
        // but its value is discarded in ROUND.
        special_d     = 1'b0;
        special_val_d = 32'd0;
        if (nan_a || nan_b || ((inf_a || inf_b) && (zero_a || zero_b))) begin
          special_d     = 1'b1;
          special_val_d = QNAN;
        end else if (inf_a || inf_b) begin
          special_d     = 1'b1;
          special_val_d = {prod_sign, 8'hFF, 23'd0};
        end else if (zero_a || zero_b) begin
          special_d     = 1'b1;
          special_val_d = {prod_sign, 31'd0};
        end
        state_d = NORM;
      end

      NORM: begin
        // Product of two [1,2) significands lies in [1,4); bit 47 marks >= 2.
        if (prod_q[47]) begin
          mant_d   = prod_q[47:24];
          guard_d  = prod_q[23];
          sticky_d = |prod_q[22:0];
          exp_d    = exp_q + 10'd1;
        end else begin
          mant_d   = prod_q[46:23];
          guard_d  = prod_q[22];
          sticky_d = |prod_q[21:0];
        end
        state_d = ROUND;
      end

      ROUND: begin
        // Nearest-even: round up above half, or at exactly half when odd.
        round_up = guard_q & (sticky_q | mant_q[0]);
        mant_rnd = {1'b0, mant_q} + {24'd0, round_up};
        exp_rnd  = exp_q;
        if (mant_rnd[24]) begin
          mant_rnd = mant_rnd >> 1;
          exp_rnd  = exp_rnd + 10'd1;
        end
        if (special_q) begin
          pack_d = special_val_q;
        end else if ($signed(exp_rnd) >= $signed(10'd255)) begin
          pack_d = {sign_q, 8'hFF, 23'd0};
        end else if ($signed(exp_rnd) <= $signed(10'd0)) begin
          pack_d = {sign_q, 31'd0};
        end else begin
          pack_d = {sign_q, exp_rnd[7:0], mant_rnd[22:0]};
        end
        state_d = DONE;
      end

      DONE: begin
        if (!done_q) begin
          result_d = pack_q;
          done_d   = 1'b1;
        end
      end

      default: state_d = LOAD;
    endcase
  end

  // State register with synchronous active-low clear; a low reset at any
  // point aborts the operation and re-arms LOAD.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= LOAD;
      a_q           <= 32'd0;
      b_q           <= 32'd0;
      sign_q        <= 1'b0;
      special_q     <= 1'b0;
      special_val_q <= 32'd0;
      exp_q         <= 10'd0;
      prod_q        <= 48'd0;
      mant_q        <= 24'd0;
      guard_q       <= 1'b0;
      sticky_q      <= 1'b0;
      pack_q        <= 32'd0;
      result_q      <= 32'd0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      a_q           <= a_d;
      b_q           <= b_d;
      sign_q        <= sign_d;
      special_q     <= special_d;
      special_val_q <= special_val_d;
      exp_q         <= exp_d;
      prod_q        <= prod_d;
      mant_q        <= mant_d;
      guard_q       <= guard_d;
      sticky_q      <= sticky_d;
      pack_q        <= pack_d;
      result_q      <= result_d;
      done_q        <= done_d;
    end
  end

  assign result = result_q;
  assign done   = done_q;

endmodule

// File: tb/tb_fpmult.sv
// tb_fpmult: directed self-checking bench for fpmult.
// Each vector pulses reset, then checks done stays low for four edges, rises
// on the fifth, and that result matches a hand-computed binary32 product.
module tb_fpmult;

  logic        clk;
  logic        reset;
  logic [31:0] dataa;
  logic [31:0] datab;
  logic [31:0] result;
  logic        done;

  int errorCount;
  int checkCount;

  fpmult dut (
    .clk   (clk),
    .reset (reset),
    .dataa (dataa),
    .datab (datab),
    .result(result),
    .done  (done)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // Pulse reset for one edge with the operands applied, then walk the five
  // edges of the operation checking done timing and the final product.
  task automatic applyStimulus(input string tag, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] expected);
    @(negedge clk);
    reset = 1'b0;
    dataa = a;
    datab = b;
    @(posedge clk);
    #1;
    checkOutput({tag, " reset done"}, {31'd0, done}, 32'd0);
    checkOutput({tag, " reset result"}, result, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk);
      #1;
      checkOutput({tag, $sformatf(" done low edge %0d", i)}, {31'd0, done}, 32'd0);
    end
    @(posedge clk);
    #1;
    checkOutput({tag, " done edge 5"}, {31'd0, done}, 32'd1);
    checkOutput({tag, " result"}, result, expected);
  endtask

  initial begin
    logic [31:0] heldResult;
    errorCount = 0;
    checkCount = 0;
    reset = 1'b0;
    dataa = 32'd0;
    datab = 32'd0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("initial reset done", {31'd0, done}, 32'd0);
    checkOutput("initial reset result", result, 32'd0);

    // Basic products
    applyStimulus("2x3",        32'h40000000, 32'h40400000, 32'h40C00000);
    applyStimulus("-1.25x1.5",  32'hBFA00000, 32'h3FC00000, 32'hBFF00000);
    applyStimulus("0x2",        32'h00000000, 32'h40000000, 32'h00000000);
    applyStimulus("-3x-2.75",   32'hC0400000, 32'hC0300000, 32'h41040000);

    // Rounding, including exact ties both ways
    applyStimulus("rnd sticky", 32'h3F800001, 32'h3F800001, 32'h3F800002);
    applyStimulus("rnd max",    32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE);
    applyStimulus("tie up",     32'h3F800001, 32'h3FC00000, 32'h3FC00002);
    applyStimulus("tie down",   32'h3F800003, 32'h3FC00000, 32'h3FC00004);

    // Specials
    applyStimulus("inf x 0",    32'h7F800000, 32'h00000000, 32'h7FC00000);
    applyStimulus("-inf x 2",   32'hFF800000, 32'h40000000, 32'hFF800000);
    applyStimulus("nan x 1",    32'h7FC00001, 32'h3F800000, 32'h7FC00000);
    applyStimulus("-0 x 2",     32'h80000000, 32'h40000000, 32'h80000000);

    // Overflow / underflow / denormal flush
    applyStimulus("overflow",   32'h7F000000, 32'h7F000000, 32'h7F800000);
    applyStimulus("underflow",  32'h00800000, 32'h00800000, 32'h00000000);
    applyStimulus("denormal",   32'h00000001, 32'h3F800000, 32'h00000000);

    // Abort in MULT: start 2x3, then reset low with new operands applied.
    @(negedge clk);
    reset = 1'b0;
    dataa = 32'h40000000;
    datab = 32'h40400000;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    dataa = 32'hBFA00000;
    datab = 32'h3FC00000;
    @(posedge clk);
    #1;
    checkOutput("abort done", {31'd0, done}, 32'd0);
    checkOutput("abort result", result, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("abort done low edge %0d", i), {31'd0, done}, 32'd0);
    end
    @(posedge clk);
    #1;
    checkOutput("abort done edge 5", {31'd0, done}, 32'd1);
    checkOutput("abort result new", result, 32'hBFF00000);

    // Hold: operands change while done is high; outputs must not move.
    heldResult = 32'hBFF00000;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      dataa = 32'h3F800000 + 32'(i * 32'h00123457);
      datab = 32'h40000000 ^ 32'(i * 32'h00ABCDEF);
      @(posedge clk);
      #1;
      checkOutput($sformatf("hold result %0d", i), result, heldResult);
      checkOutput($sformatf("hold done %0d", i), {31'd0, done}, 32'd1);
    end

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
